// File: rtl/chip_valve_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : chip_valve_sequencer_if
//  Description : Command handshake, status and pad-drive bundle of the ChIP
//                valve sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface chip_valve_sequencer_if #(
  parameter int CNT_W = 16
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [2:0]       cmd_sel;
  logic [CNT_W-1:0] cmd_count;
  logic             abort;
  logic             busy;
  logic             done;
  logic             aborted;
  logic             err;
  logic [4:0]       ctrl_inlet;
  logic [1:0]       ctrl_prep_outlet;
  logic             ctrl_v1;
  logic             ctrl_v2;
  logic             ctrl_sieve;
  logic             ctrl_collect;
  logic             ctrl_bead;
  logic [2:0]       pump;

  modport master (
    output cmd_valid, cmd_op, cmd_sel, cmd_count, abort,
    input  cmd_ready, busy, done, aborted, err,
    input  ctrl_inlet, ctrl_prep_outlet, ctrl_v1, ctrl_v2, ctrl_sieve,
    input  ctrl_collect, ctrl_bead, pump
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_sel, cmd_count, abort,
    output cmd_ready, busy, done, aborted, err,
    output ctrl_inlet, ctrl_prep_outlet, ctrl_v1, ctrl_v2, ctrl_sieve,
    output ctrl_collect, ctrl_bead, pump
  );
endinterface
`default_nettype wire

// File: rtl/chip_valve_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : chip_valve_sequencer
//  Description : Command-driven ChIP control-layer sequencer: open a valve
//                set, settle, pump N strokes, close everything, settle.
//  Revision    : 1.0 - initial release
// ============================================================================
module chip_valve_sequencer #(
  parameter int PUMP_DIV = 4,
  parameter int SETTLE   = 8,
  parameter int CNT_W    = 16
) (
  input  wire logic               clk,
  input  wire logic               rst,
  chip_valve_sequencer_if.slave   io_bus
);
  localparam logic [1:0] C_IDLE    = 2'd0;
  localparam logic [1:0] C_SETTLE  = 2'd1;
  localparam logic [1:0] C_PUMP    = 2'd2;
  localparam logic [1:0] C_RELEASE = 2'd3;

  localparam int TMR_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int DIV_W = (PUMP_DIV > 1) ? $clog2(PUMP_DIV) : 1;
  localparam logic [TMR_W-1:0] C_TMR_LAST   = TMR_W'(SETTLE - 1);
  localparam logic [TMR_W-1:0] C_TMR_ONE    = TMR_W'(1);
  localparam logic [DIV_W-1:0] C_DIV_LAST   = DIV_W'(PUMP_DIV - 1);
  localparam logic [DIV_W-1:0] C_DIV_ONE    = DIV_W'(1);
  localparam logic [CNT_W-1:0] C_STROKE_ONE = CNT_W'(1);

  logic [1:0]       r_state, w_state_nxt;
  logic [TMR_W-1:0] r_tmr, w_tmr_nxt;
  logic [DIV_W-1:0] r_div, w_div_nxt;
  logic [2:0]       r_phase, w_phase_nxt;
  logic [CNT_W-1:0] r_strokes, w_strokes_nxt;
  logic [11:0]      r_vset, w_vset_nxt;   // {inlet, prep, v1, v2, sieve, collect, bead}
  logic             r_abt, w_abt_nxt;

  logic [4:0]  w_cmd_inlet;
  logic [1:0]  w_cmd_prep;
  logic        w_cmd_v1, w_cmd_v2, w_cmd_collect, w_cmd_bead, w_cmd_ok;
  logic [11:0] w_cmd_vset;
  logic        w_accept, w_is_nop, w_tmr_last, w_pump_last;

  logic        r_ready, r_busy, r_done, r_aborted, r_err;
  logic [11:0] r_valves;
  logic [2:0]  r_pump;
  logic        w_ready_nxt, w_busy_nxt, w_done_nxt, w_aborted_nxt, w_err_nxt;
  logic [11:0] w_valves_nxt;
  logic [2:0]  w_pump_nxt;

  assign w_accept    = io_bus.cmd_valid && (r_state == C_IDLE);
  assign w_is_nop    = (io_bus.cmd_op == 3'd0);
  assign w_tmr_last  = (r_tmr == C_TMR_LAST);
  assign w_pump_last = (r_div == C_DIV_LAST) && (r_phase == 3'd5) && (r_strokes == C_STROKE_ONE);
  assign w_cmd_vset  = {w_cmd_inlet, w_cmd_prep, w_cmd_v1, w_cmd_v2, 1'b1, w_cmd_collect, w_cmd_bead};

  // Valve set for the command on the bus; the sieve is never opened.
  always_comb begin : p_decode
    w_cmd_inlet   = '1;
    w_cmd_prep    = '1;
    w_cmd_v1      = 1'b1;
    w_cmd_v2      = 1'b1;
    w_cmd_collect = 1'b1;
    w_cmd_bead    = 1'b1;
    w_cmd_ok      = 1'b0;
    case (io_bus.cmd_op)
      3'd1: if (io_bus.cmd_sel < 3'd5) begin
        w_cmd_ok                     = 1'b1;
        w_cmd_inlet[io_bus.cmd_sel] = 1'b0;
        w_cmd_v1                     = 1'b0;
      end
      3'd2: w_cmd_ok = 1'b1;
      3'd3: if (io_bus.cmd_sel < 3'd2) begin
        w_cmd_ok                      = 1'b1;
        w_cmd_prep[io_bus.cmd_sel[0]] = 1'b0;
        w_cmd_v2                      = 1'b0;
        w_cmd_collect                 = 1'b0;
      end
      3'd4: begin
        w_cmd_ok   = 1'b1;
        w_cmd_bead = 1'b0;
        w_cmd_v1   = 1'b0;
      end
      default: w_cmd_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin : p_state_reg
    if (rst) begin
      r_state   <= C_IDLE;
      r_tmr     <= '0;
      r_div     <= '0;
      r_phase   <= 3'd0;
      r_strokes <= '0;
      r_vset    <= '1;
      r_abt     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_tmr     <= w_tmr_nxt;
      r_div     <= w_div_nxt;
      r_phase   <= w_phase_nxt;
      r_strokes <= w_strokes_nxt;
      r_vset    <= w_vset_nxt;
      r_abt     <= w_abt_nxt;
    end
  end

  always_comb begin : p_next_state
    w_state_nxt = r_state;
    w_abt_nxt   = r_abt;
    case (r_state)
      C_IDLE: if (w_accept && w_cmd_ok) begin
        w_state_nxt = C_SETTLE;
        w_abt_nxt   = 1'b0;
      end
      C_SETTLE: if (io_bus.abort) begin
        w_state_nxt = C_RELEASE;
        w_abt_nxt   = 1'b1;
      end else if (w_tmr_last) begin
        w_state_nxt = (r_strokes == '0) ? C_RELEASE : C_PUMP;
      end
      C_PUMP: if (io_bus.abort) begin
        w_state_nxt = C_RELEASE;
        w_abt_nxt   = 1'b1;
      end else if (w_pump_last) begin
        w_state_nxt = C_RELEASE;
      end
      default: if (w_tmr_last) w_state_nxt = C_IDLE;
    endcase
  end

  // Timer restarts on every state change; phase/divider idle at zero outside PUMP.
  always_comb begin : p_datapath
    w_tmr_nxt     = '0;
    w_div_nxt     = '0;
    w_phase_nxt   = 3'd0;
    w_strokes_nxt = r_strokes;
    w_vset_nxt    = r_vset;
    if ((w_state_nxt == r_state) && ((r_state == C_SETTLE) || (r_state == C_RELEASE)))
      w_tmr_nxt = r_tmr + C_TMR_ONE;
    if (w_accept && w_cmd_ok) begin
      w_strokes_nxt = io_bus.cmd_count;
      w_vset_nxt    = w_cmd_vset;
    end
    if (r_state == C_PUMP) begin
      w_phase_nxt = r_phase;
      if (r_div == C_DIV_LAST) begin
        if (r_phase == 3'd5) begin
          w_phase_nxt   = 3'd0;
          w_strokes_nxt = r_strokes - C_STROKE_ONE;
        end else begin
          w_phase_nxt = r_phase + 3'd1;
        end
      end else begin
        w_div_nxt = r_div + C_DIV_ONE;
      end
    end
  end

  always_comb begin : p_outputs
    w_ready_nxt   = (w_state_nxt == C_IDLE);
    w_busy_nxt    = (w_state_nxt != C_IDLE);
    w_done_nxt    = (w_accept && w_is_nop) ||
                    ((r_state == C_RELEASE) && (w_state_nxt == C_IDLE));
    w_aborted_nxt = (r_state == C_RELEASE) && (w_state_nxt == C_IDLE) && r_abt;
    w_err_nxt     = w_accept && !w_cmd_ok && !w_is_nop;
    w_valves_nxt  = '1;
    w_pump_nxt    = 3'b111;
    if ((w_state_nxt == C_SETTLE) || (w_state_nxt == C_PUMP))
      w_valves_nxt = w_vset_nxt;
    if (w_state_nxt == C_PUMP) begin
      case (w_phase_nxt)
        3'd0:    w_pump_nxt = 3'b011;
        3'd1:    w_pump_nxt = 3'b001;
        3'd2:    w_pump_nxt = 3'b101;
        3'd3:    w_pump_nxt = 3'b100;
        3'd4:    w_pump_nxt = 3'b110;
        default: w_pump_nxt = 3'b010;
      endcase
    end
  end

  always_ff @(posedge clk) begin : p_out_reg
    if (rst) begin
      r_ready   <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
      r_err     <= 1'b0;
      r_valves  <= '1;
      r_pump    <= 3'b111;
    end else begin
      r_ready   <= w_ready_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_aborted <= w_aborted_nxt;
      r_err     <= w_err_nxt;
      r_valves  <= w_valves_nxt;
      r_pump    <= w_pump_nxt;
    end
  end

  assign io_bus.cmd_ready        = r_ready;
  assign io_bus.busy             = r_busy;
  assign io_bus.done             = r_done;
  assign io_bus.aborted          = r_aborted;
  assign io_bus.err              = r_err;
  assign io_bus.ctrl_inlet       = r_valves[11:7];
  assign io_bus.ctrl_prep_outlet = r_valves[6:5];
  assign io_bus.ctrl_v1          = r_valves[4];
  assign io_bus.ctrl_v2          = r_valves[3];
  assign io_bus.ctrl_sieve       = r_valves[2];
  assign io_bus.ctrl_collect     = r_valves[1];
  assign io_bus.ctrl_bead        = r_valves[0];
  assign io_bus.pump             = r_pump;
endmodule
`default_nettype wire

// File: tb/tb_chip_valve_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_chip_valve_sequencer
//  Description : Directed plus random command bench with a timeline model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_chip_valve_sequencer;
  localparam int SETTLE   = 2;
  localparam int PUMP_DIV = 1;
  localparam int CNT_W    = 16;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  chip_valve_sequencer_if #(.CNT_W(CNT_W)) bus ();

  chip_valve_sequencer #(
    .PUMP_DIV (PUMP_DIV),
    .SETTLE   (SETTLE),
    .CNT_W    (CNT_W)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus)
  );

  // {ready, busy, done, aborted, err, inlet5, prep2, v1, v2, sieve, collect, bead, pump3}
  logic [19:0] obs;
  assign obs = {bus.cmd_ready, bus.busy, bus.done, bus.aborted, bus.err,
                bus.ctrl_inlet, bus.ctrl_prep_outlet, bus.ctrl_v1, bus.ctrl_v2,
                bus.ctrl_sieve, bus.ctrl_collect, bus.ctrl_bead, bus.pump};

  function automatic logic [19:0] pack(input logic rdy, bsy, dn, ab, er,
                                       input logic [11:0] v, input logic [2:0] p);
    return {rdy, bsy, dn, ab, er, v, p};
  endfunction

  function automatic bit legal(input logic [2:0] op, input logic [2:0] sel);
    case (op)
      3'd1:    return sel < 3'd5;
      3'd2:    return 1'b1;
      3'd3:    return sel < 3'd2;
      3'd4:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [11:0] valves_for(input logic [2:0] op, input logic [2:0] sel);
    logic [4:0] inl  = '1;
    logic [1:0] prep = '1;
    logic v1 = 1'b1, v2 = 1'b1, col = 1'b1, bd = 1'b1;
    if (op == 3'd1) begin inl[sel] = 1'b0; v1 = 1'b0; end
    if (op == 3'd3) begin prep[sel[0]] = 1'b0; v2 = 1'b0; col = 1'b0; end
    if (op == 3'd4) begin bd = 1'b0; v1 = 1'b0; end
    return {inl, prep, v1, v2, 1'b1, col, bd};
  endfunction

  function automatic int rel_start(input int cnt, input int abt);
    return (abt > 0) ? abt + 1 : SETTLE + cnt * 6 * PUMP_DIV + 1;
  endfunction

  function automatic int last_k(input logic [2:0] op, input logic [2:0] sel,
                                input int cnt, input int abt);
    return legal(op, sel) ? rel_start(cnt, abt) + SETTLE : 2;
  endfunction

  // Expected outputs k cycles after the accepting edge.
  function automatic logic [19:0] exp_at(input logic [2:0] op, input logic [2:0] sel,
                                         input int cnt, input int abt, input int k);
    logic [2:0] pat [6] = '{3'b011, 3'b001, 3'b101, 3'b100, 3'b110, 3'b010};
    int rel = rel_start(cnt, abt);
    int dn  = rel + SETTLE;
    if (!legal(op, sel))
      return pack(1'b1, 1'b0, (op == 3'd0) && (k == 1), 1'b0, (op != 3'd0) && (k == 1),
                  12'hFFF, 3'b111);
    if (k < rel)
      return pack(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, valves_for(op, sel),
                  (k > SETTLE) ? pat[((k - SETTLE - 1) / PUMP_DIV) % 6] : 3'b111);
    if (k < dn)
      return pack(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12'hFFF, 3'b111);
    return pack(1'b1, 1'b0, k == dn, (k == dn) && (abt > 0), 1'b0, 12'hFFF, 3'b111);
  endfunction

  task automatic check(input string tag, input logic [19:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Presents a command at a negedge; returns at the negedge of its last checked cycle.
  task automatic run_cmd(input logic [2:0] op, input logic [2:0] sel, input int cnt,
                         input int abt, input bit hold, input int stop_k, input string name);
    int  kend = (stop_k > 0) ? stop_k : last_k(op, sel, cnt, abt);
    int  rel  = rel_start(cnt, abt);
    bit  lg   = legal(op, sel);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_sel   = sel;
    bus.cmd_count = CNT_W'(cnt);
    bus.abort     = 1'($urandom_range(0, 1));
    @(posedge clk);
    for (int k = 1; k <= kend; k++) begin
      @(negedge clk);
      check($sformatf("%s k=%0d", name, k), exp_at(op, sel, cnt, abt, k));
      if (!hold) bus.cmd_valid = 1'b0;
      if (k == abt)
        bus.abort = 1'b1;
      else if (lg && (k >= rel))
        bus.abort = 1'($urandom_range(0, 1));
      else
        bus.abort = 1'b0;
    end
  endtask

  initial begin
    logic [2:0] op, sel;
    int         cnt, abt;
    bit         hold;

    rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 3'd0;
    bus.cmd_sel   = 3'd0;
    bus.cmd_count = '0;
    bus.abort     = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset", pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'hFFF, 3'b111));
    rst = 1'b0;
    @(negedge clk);
    check("idle", pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'hFFF, 3'b111));

    run_cmd(3'd1, 3'd2, 1, 0, 1'b0, 0, "load_s2_c1");
    run_cmd(3'd3, 3'd1, 0, 0, 1'b0, 0, "elute_s1_c0");
    run_cmd(3'd6, 3'd0, 1, 0, 1'b0, 0, "illegal_op6");
    run_cmd(3'd1, 3'd5, 1, 0, 1'b0, 0, "load_sel5");
    run_cmd(3'd3, 3'd2, 1, 0, 1'b0, 0, "elute_sel2");
    run_cmd(3'd0, 3'd0, 4, 0, 1'b0, 0, "nop");
    run_cmd(3'd2, 3'd0, 3, 5, 1'b0, 0, "mix_abort5");
    run_cmd(3'd4, 3'd0, 2, 1, 1'b0, 0, "bead_abort_settle");
    run_cmd(3'd1, 3'd4, 2, 0, 1'b0, 0, "load_s4_c2");

    run_cmd(3'd2, 3'd0, 3, 0, 1'b0, 4, "mix_pre_rst");
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_in_pump", pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'hFFF, 3'b111));
    rst = 1'b0;
    run_cmd(3'd1, 3'd0, 1, 0, 1'b0, 0, "load_after_rst");

    run_cmd(3'd4, 3'd0, 1, 0, 1'b1, 0, "bead_b2b_1");
    run_cmd(3'd4, 3'd0, 1, 0, 1'b0, 0, "bead_b2b_2");

    for (int i = 0; i < 40; i++) begin
      op   = ($urandom_range(0, 3) != 0) ? 3'($urandom_range(1, 4)) : 3'($urandom_range(0, 7));
      sel  = 3'($urandom_range(0, 5));
      cnt  = $urandom_range(0, 3);
      abt  = 0;
      if (legal(op, sel) && ($urandom_range(0, 2) == 0))
        abt = $urandom_range(1, SETTLE + cnt * 6 * PUMP_DIV);
      hold = legal(op, sel) && ($urandom_range(0, 3) == 0);
      run_cmd(op, sel, cnt, abt, hold, 0, $sformatf("rnd%0d_op%0d", i, op));
    end

    bus.cmd_valid = 1'b0;
    bus.abort     = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("final_idle", pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'hFFF, 3'b111));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
